// File: rtl/window_gen_if.sv
// window_gen_if: raster pixel input stream bundle for window_gen.
// pix_in_sof exists only when WINGEN_SOF_EN is defined.
interface window_gen_if #(
    parameter int PIX_BITS = 8
);
    logic [PIX_BITS-1:0] pix_in_data;
    logic                pix_in_valid;
`ifdef WINGEN_SOF_EN
    logic                pix_in_sof;

    modport master (output pix_in_data, pix_in_valid, pix_in_sof);
    modport slave  (input  pix_in_data, pix_in_valid, pix_in_sof);
`else
    modport master (output pix_in_data, pix_in_valid);
    modport slave  (input  pix_in_data, pix_in_valid);
`endif
endinterface

// File: rtl/window_gen.sv
// window_gen: 3x3 sliding window over a raster stream, valid-only output.
// Define WINGEN_SOF_EN to add pix_in_sof for mid-stream frame resync.
module window_gen #(
    parameter int PIX_BITS = 8,
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int NM       = 9
) (
    input  logic                clk,
    input  logic                rst,
    window_gen_if.slave         pix_if,
    output logic [PIX_BITS-1:0] win_data [NM-1:0],
    output logic                win_valid,
    output logic                frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]       col_q, col_d, col_eff;
    logic [RW-1:0]       row_q, row_d, row_eff;
    logic [PIX_BITS-1:0] lb1_q [IMG_W];
    logic [PIX_BITS-1:0] lb2_q [IMG_W];
    logic [PIX_BITS-1:0] win_q [NM-1:0];
    logic [PIX_BITS-1:0] win_d [NM-1:0];
    logic [PIX_BITS-1:0] rd1, rd2, pix;
    logic                acc, restart;
    logic                last_col, last_row, win_hit;

    assign acc = pix_if.pix_in_valid;
    assign pix = pix_if.pix_in_data;

`ifdef WINGEN_SOF_EN
    assign restart = pix_if.pix_in_sof;
`else
    assign restart = 1'b0;
`endif

    // A start-of-frame beat is pixel (0,0) whatever the counters say
    assign col_eff  = restart ? '0 : col_q;
    assign row_eff  = restart ? '0 : row_q;
    assign last_col = (col_eff == CW'(IMG_W - 1));
    assign last_row = (row_eff == RW'(IMG_H - 1));
    assign win_hit  = (row_eff >= RW'(2)) && (col_eff >= CW'(2));

    assign rd1 = lb1_q[col_eff];
    assign rd2 = lb2_q[col_eff];

    always_comb begin
        col_d = col_eff + CW'(1);
        row_d = row_eff;
        if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_eff + RW'(1);
        end
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_d[3*r]   = win_q[3*r+1];
            win_d[3*r+1] = win_q[3*r+2];
            win_d[3*r+2] = win_q[3*r+2];
        end
        win_d[2] = rd2;
        win_d[5] = rd1;
        win_d[8] = pix;
    end

    // Line storage is deliberately unreset; rows 0-1 never emit windows
    always_ff @(posedge clk) begin
        if (acc) begin
            lb1_q[col_eff] <= pix;
            lb2_q[col_eff] <= rd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < NM; i++) begin
                win_q[i]    <= '0;
                win_data[i] <= '0;
            end
        end else begin
            win_valid  <= acc && win_hit;
            frame_done <= acc && last_col && last_row;
            if (acc) begin
                col_q <= col_d;
                row_q <= row_d;
                win_q <= win_d;
                if (win_hit) begin
                    win_data <= win_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_window_gen.sv
// tb_window_gen: scoreboard bench for window_gen on a 4x4 image.
// Pixel value = base + row*16 + col; WINGEN_SOF_EN adds a resync case.
module tb_window_gen;
    localparam int PB = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int NM = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic [PB-1:0] win_data [NM-1:0];
    logic          win_valid;
    logic          frame_done;

    always #5 clk = ~clk;

    window_gen_if #(.PIX_BITS(PB)) pif ();

    window_gen #(
        .PIX_BITS(PB),
        .IMG_W(W),
        .IMG_H(H),
        .NM(NM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pix_if(pif),
        .win_data(win_data),
        .win_valid(win_valid),
        .frame_done(frame_done)
    );

    typedef struct packed {
        int unsigned              cyc;
        logic                     fd;
        logic [NM-1:0][PB-1:0]    w;
    } exp_t;

    exp_t        sb [$];
    exp_t        e;
    int          passed = 0;
    int          total  = 0;
    int          n_win  = 0;
    int          n_fd   = 0;
    int unsigned cyc    = 0;
`ifdef WINGEN_SOF_EN
    bit          sof_next = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [PB-1:0] px(input logic [PB-1:0] base,
                                         input int r, input int c);
        return base + PB'(r * 16 + c);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_done) begin
                n_fd++;
                chk("fd_with_window", int'(win_valid), 1);
            end
            if (win_valid) begin
                n_win++;
                chk("sb_nonempty", int'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("win_cycle", int'(cyc), int'(e.cyc));
                    for (int i = 0; i < NM; i++)
                        chk($sformatf("win[%0d]", i), int'(win_data[i]),
                            int'(e.w[i]));
                    chk("frame_done", int'(frame_done), int'(e.fd));
                end
            end
        end
    end

    task automatic beat(input logic [PB-1:0] d, input int gap);
        pif.pix_in_data  = d;
        pif.pix_in_valid = 1'b1;
        @(posedge clk);
        #1;
        pif.pix_in_valid = 1'b0;
`ifdef WINGEN_SOF_EN
        pif.pix_in_sof   = 1'b0;
`endif
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input logic [PB-1:0] base, input int gap,
                         input int nb);
        exp_t x;
        for (int k = 0; k < nb; k++) begin
            int r = k / W;
            int c = k % W;
            if (r >= 2 && c >= 2) begin
                x.cyc = cyc + 1;
                x.fd  = (r == H - 1) && (c == W - 1);
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        x.w[3*i+j] = px(base, r - 2 + i, c - 2 + j);
                sb.push_back(x);
            end
`ifdef WINGEN_SOF_EN
            pif.pix_in_sof = sof_next && (k == 0);
`endif
            beat(px(base, r, c), gap);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_win_valid", int'(win_valid), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        for (int i = 0; i < NM; i++)
            chk($sformatf("rst_win[%0d]", i), int'(win_data[i]), 0);
    endtask

    task automatic finish_case(input string nm, input int wins,
                               input int fds);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk({nm, "_windows"}, n_win, wins);
        chk({nm, "_fd_pulses"}, n_fd, fds);
        chk({nm, "_sb_empty"}, int'(sb.size()), 0);
        n_win = 0;
        n_fd  = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst              = 1'b1;
        pif.pix_in_data  = '0;
        pif.pix_in_valid = 1'b0;
`ifdef WINGEN_SOF_EN
        pif.pix_in_sof   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        frame(8'h00, 0, W * H);
        finish_case("contig", 4, 1);

        frame(8'h00, 3, W * H);
        finish_case("gaps", 4, 1);

        frame(8'h00, 0, W * H);
        frame(8'h80, 0, W * H);
        finish_case("b2b", 8, 2);

        frame(8'h40, 0, 7);
        do_reset();
        frame(8'h10, 1, W * H);
        finish_case("midrst", 4, 1);

`ifdef WINGEN_SOF_EN
        frame(8'h00, 0, 9);
        sof_next = 1'b1;
        frame(8'h40, 0, W * H);
        sof_next = 1'b0;
        finish_case("sof", 4, 1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
